// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control into EX, inserts load-use and flush bubbles.
// Latency: 1 cycle ID->EX; load_use_stall and the WB->ID operand bypass are combinational.
// Backpressure: stall_mem freezes all EX state; load_use_stall asks PC/IF-ID to hold while a bubble enters EX.
//
// Optional feature macro: ID_EX_PERF_CNT_EN adds the CNT_W parameter and the bubble_cnt/flush_cnt ports.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   stall_mem, flush                global freeze, branch/jump kill of the ID instruction
//   id_*                            decoded instruction in ID (valid, indices, operands, imm, pc, ctrl)
//   wb_regwrite, wb_rd, wb_data     register-file write happening this cycle (bypassed into ID)
//   load_use_stall                  combinational hazard request to upstream
//   ex_*                            registered instruction presented to EX
//   bubble_cnt, flush_cnt           saturating perf counters (macro builds only)
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
`ifdef ID_EX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_mem,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rs1_dat;
    logic [XLEN-1:0]   rs2_dat;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t ex_q, ex_d;

  logic            rs1_hit, rs2_hit;
  logic [XLEN-1:0] rs1_byp, rs2_byp;

  // Hazard only against a real load in EX that writes a non-zero register.
  // A flushed ID instruction never needs to wait, so flush masks the request.
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_q.rd);
  assign load_use_stall = !flush && id_valid && ex_q.valid && ex_q.ctrl[1] &&
                          (ex_q.rd != 5'd0) && (rs1_hit || rs2_hit);

  // The register file is written at the end of this cycle, so its read port
  // still shows the old value; take the WB data directly. x0 stays zero.
  assign rs1_byp = (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
  assign rs2_byp = (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

  always_comb begin
    ex_d = ex_q;
    if (!stall_mem) begin
      if (flush || load_use_stall) begin
        // Bubble: all-zero so regwrite/memread/memwrite and rd are cleared.
        ex_d = '0;
      end else begin
        ex_d.valid   = id_valid;
        ex_d.rs1     = id_rs1;
        ex_d.rs2     = id_rs2;
        ex_d.rd      = id_valid ? id_rd : 5'd0;
        ex_d.rs1_dat = rs1_byp;
        ex_d.rs2_dat = rs2_byp;
        ex_d.imm     = id_imm;
        ex_d.pc      = id_pc;
        ex_d.ctrl    = id_valid ? id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1_data = ex_q.rs1_dat;
  assign ex_rs2_data = ex_q.rs2_dat;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;
  assign ex_ctrl     = ex_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;
  logic             bubble_evt, flush_evt;

  // load_use_stall is already masked by flush, so the two events are exclusive.
  assign bubble_evt = !stall_mem && load_use_stall;
  assign flush_evt  = !stall_mem && flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bubble_evt && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
      if (flush_evt && (flush_cnt_q != '1))   flush_cnt_q  <= flush_cnt_q + CNT_ONE;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, directly upstream of the EX-stage forwarding unit.
- Registers decoded operands, register indices, immediate, PC and control bundle into EX.
- Detects load-use hazards, inserts a bubble, and honours memory-freeze and branch-flush.
- Applies a WB-to-ID same-cycle register-file bypass so operands captured into EX are never stale.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- CTRL_W, 10, control bundle width. Bit 0 = regwrite, bit 1 = memread, bit 2 = memwrite; the remaining bits pass through opaquely.
- CNT_W, 16, width of the optional perf counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_mem  in  1  global freeze from the D/I-cache; holds the whole pipeline.
- flush  in  1  branch/jump taken in EX; kills the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- id_rd  in  5  destination index.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm, id_pc  in  XLEN  immediate and PC.
- id_ctrl  in  CTRL_W  decoded control bundle.
- wb_regwrite  in  1  WB stage writes the register file this cycle.
- wb_rd  in  5  WB destination.
- wb_data  in  XLEN  WB write data.
- load_use_stall  out  1  combinational; holds PC and IF/ID.
- ex_valid  out  1  EX holds a real instruction.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices (ex_rs1/ex_rs2 drive the forwarding unit).
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN  registered operands.
- ex_ctrl  out  CTRL_W  registered control bundle.
- bubble_cnt, flush_cnt  out  CNT_W  perf counters (present only with the macro).

Behaviour:
- Reset (async assert, sync release): all ex_* outputs = 0, ex_valid = 0, counters = 0. A reset mid-stall discards the held instruction.

Hazard detection (combinational):
- load_use_stall = id_valid & ex_valid & ex_ctrl[1] & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Forced to 0 when flush = 1, because the ID instruction is being killed.

Bypass (combinational, applied before capture):
- rs1 captured value = wb_data if wb_regwrite & wb_rd != 0 & wb_rd == id_rs1; otherwise id_rs1_data.
- rs2 is handled the same way.
- x0 is never bypassed.

Register update per rising clk, highest priority first:
1. stall_mem = 1: hold every ex_* register unchanged, including ex_valid. load_use_stall is still driven but has no effect. flush is ignored and the branch unit re-asserts it after the freeze.
2. flush = 1: insert bubble. ex_valid = 0 and ex_ctrl = 0 (regwrite/memread/memwrite cleared). ex_rd = 0. Data fields don't-care; drive 0.
3. load_use_stall = 1: insert bubble exactly as in flush. The upstream hold re-presents the same ID instruction next cycle, and the hazard is then cleared.
4. Otherwise load: ex_valid = id_valid and all fields are captured. If id_valid = 0, ex_ctrl = 0 and ex_rd = 0.

Timing and boundaries:
- Latency: 1 cycle from ID to EX.
- A load followed by a dependent instruction yields exactly one bubble.
- Back-to-back loads chaining through the same rd yield one bubble per dependent instruction.
- flush and load_use_stall together: flush wins, and load_use_stall output = 0.
- Bubbles never assert regwrite, so the forwarding unit sees no false match.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: bubble_cnt increments on each load-use bubble edge, and flush_cnt increments on each flush bubble edge. Neither counts while stall_mem = 1. Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: the counter ports and logic are absent.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with id_valid = 1 → all ex_* = 0 immediately, load_use_stall = 0.
- Load-use: EX holds lw x5 (ex_ctrl[1] = 1, ex_rd = 5) and ID holds add x6,x5,x7 → load_use_stall = 1 for 1 cycle, then ex_valid = 0 and ex_ctrl = 0. The next cycle captures the add with ex_rs1 = 5.
- x0 and unused operands: lw x0 followed by use of x0 → no stall. lw x5 followed by lui x6 (id_use_rs1 = 0, id_rs1 = 5) → no stall.
- Flush priority: flush = 1 together with a load-use condition → load_use_stall = 0, bubble inserted, flush_cnt = 1 and bubble_cnt = 0 (with ID_EX_PERF_CNT_EN).
- Freeze: stall_mem = 1 for 3 cycles while id_* change and flush pulses → ex_* hold their previous values (e.g. ex_pc = 0x0000_0040) throughout.
- WB bypass: wb_regwrite = 1, wb_rd = 3, wb_data = 0xDEADBEEF, id_rs2 = 3, id_rs2_data = 0 → ex_rs2_data = 0xDEADBEEF. The same case with wb_rd = 0 → ex_rs2_data = 0.
